// File: rtl/sub_8_seq.sv
// Sequential unsigned subtractor: D = A - B (mod 2^WIDTH) plus borrow,
// computed DIGIT bits per cycle, LSB chunk first, behind valid/ready handshakes.
module sub_8_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow,
    output logic [1:0]       state_dbg
);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("sub_8_seq: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bin_q, bin_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   diff;
    logic [WIDTH-1:0] chunk_ext;
    logic [WIDTH-1:0] acc_shift;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE and out_valid only in DONE, both
    // decoded from the state register so neither depends combinationally on inputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        d_d     = d_q;
        bin_d   = bin_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;

        diff      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(bin_q);
        chunk_ext = '0;
        chunk_ext[DIGIT-1:0] = diff[DIGIT-1:0];
        acc_shift = (acc_q >> DIGIT) | (chunk_ext << (WIDTH - DIGIT));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                acc_d = acc_shift;
                bin_d = diff[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish to the held output only once the last chunk lands.
                    d_d     = acc_shift;
                    brw_d   = diff[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            bin_q   <= 1'b0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            bin_q   <= bin_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign borrow    = brw_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sub_8_seq.sv
// Bench for sub_8_seq: directed operations feed an expected queue that a
// negedge monitor drains on every output handshake.
module tb_sub_8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] D;
    logic       borrow;
    logic [1:0] state_dbg;

    int checks  = 0;
    int errors  = 0;
    int sent    = 0;
    int results = 0;
    bit sweep_on = 1'b0;

    logic [8:0] exp_q[$];

    sub_8_seq #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .D(D), .borrow(borrow),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops on each handshake, and checks stability while backpressured.
    logic [8:0] held;
    bit         hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {borrow, D}, held);
            end
            if (out_valid && out_ready) begin
                results++;
                hold = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("result_D", D, e[7:0]);
                    check("result_borrow", borrow, e[8]);
                end
            end else if (out_valid) begin
                hold = 1'b1;
                held = {borrow, D};
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        logic [8:0] e;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        A = a;
        B = b;
        e[7:0] = a - b;
        e[8]   = (a < b);
        exp_q.push_back(e);
        sent++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_release();
        int n = 0;
        while (out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("release_timeout", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        int lat;
        send(a, b);
        check("in_ready_run", in_ready, 0);
        wait_valid(lat);
        check("latency", lat, 4);
        check("in_ready_done", in_ready, 0);
        wait_release();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] va[6] = '{8'd100, 8'd25, 8'd255, 8'd0, 8'd0,   8'd62};
        logic [7:0] vb[6] = '{8'd200, 8'd37, 8'd1,   8'd0, 8'd255, 8'd37};

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_borrow", borrow, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        out_ready = 1'b1;
        run_op(8'd62, 8'd37);
        for (int i = 0; i < 6; i++) run_op(va[i], vb[i]);

        // Backpressure: result must stay put for 5 cycles.
        out_ready = 1'b0;
        send(8'd200, 8'd100);
        wait_valid(lat);
        check("bp_latency", lat, 4);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_D", D, 100);
            check("bp_borrow", borrow, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drop", out_valid, 0);
        check("bp_in_ready", in_ready, 1);

        // Inputs presented during RUN are ignored.
        send(8'd62, 8'd37);
        in_valid = 1'b1;
        A = 8'd9;
        B = 8'd3;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        wait_valid(lat);
        check("ign_latency", lat, 2);
        check("ign_D", D, 25);
        wait_release();
        repeat (10) begin @(posedge clk); #1; end
        check("ign_no_extra", results, sent);
        check("ign_queue_empty", exp_q.size(), 0);

        // Reset in the middle of RUN discards the partial result.
        send(8'd100, 8'd200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        sent--;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_D", D, 0);
        check("mid_rst_borrow", borrow, 0);
        check("mid_rst_in_ready", in_ready, 1);
        run_op(8'd62, 8'd37);

        // Random pairs with random consumer backpressure.
        sweep_on = 1'b1;
        fork
            begin
                while (sweep_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 2500; i++)
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        sweep_on = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        check("final_count", results, sent);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
